// File: rtl/conv_accum_pkg.sv
// Shared widths, default shifts and the control word carried down the conv_accum pipeline.
package conv_accum_pkg;

    localparam int BYTE      = 8;
    localparam int HALF_WORD = 16;
    localparam int WORD      = 32;

    localparam int DATA_W = BYTE;
    localparam int COEF_W = BYTE;
    localparam int SUM_W  = WORD + 1;

    localparam int DEF_OUT_SHIFT  = 9;
    localparam int DEF_BIAS_SHIFT = 0;

    typedef struct packed {
        logic vld;
        logic save;
        logic fin;
    } ctrl_t;

endpackage

// File: rtl/conv_accum_requant.sv
// Combinational requantizer: round-half-up arithmetic shift, int8 saturation, optional ReLU.
module conv_requant
    import conv_accum_pkg::*;
#(
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    parameter bit RELU      = 1'b0
) (
    input  logic signed [SUM_W-1:0] sum,
    output logic signed [BYTE-1:0]  q,
    output logic                    sat
);

    localparam logic signed [SUM_W-1:0] Q_MAX = 127;
    localparam logic signed [SUM_W-1:0] Q_MIN = -128;

    function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] half;
        half = SUM_W'((64'd1 << OUT_SHIFT) >> 1);
        return (v + half) >>> OUT_SHIFT;
    endfunction

    function automatic logic clipped(input logic signed [SUM_W-1:0] r);
        return (r > Q_MAX) || (r < Q_MIN);
    endfunction

    function automatic logic signed [BYTE-1:0] saturate(input logic signed [SUM_W-1:0] r);
        if (r > Q_MAX) return BYTE'(Q_MAX);
        if (r < Q_MIN) return BYTE'(Q_MIN);
        return BYTE'(r);
    endfunction

    logic signed [SUM_W-1:0] r;

    always_comb begin
        r   = round_shift(sum);
        sat = clipped(r);
        q   = saturate(r);
        // ReLU runs after saturation so a clipped negative still counts as saturated.
        if (RELU && q < 0) q = '0;
    end

endmodule

// File: rtl/conv_accum.sv
// Execute end of the en_sum/save/finish protocol: multiply-accumulate, bias add, requantize, write.
// save sampled at edge E0 produces out_we after edge E0+3; done follows finish with the same latency.
module conv_accum
    import conv_accum_pkg::*;
#(
    parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
    parameter int BIAS_SHIFT = DEF_BIAS_SHIFT,
    parameter bit RELU       = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en_sum,
    input  logic                        save,
    input  logic                        finish,
    input  logic [HALF_WORD-1:0]        s_addr,
    input  logic [HALF_WORD-1:0]        w_addr,
    input  logic [HALF_WORD-1:0]        b_addr,
    input  logic [HALF_WORD-1:0]        save_addr,
    output logic                        s_rd_en,
    output logic                        w_rd_en,
    output logic                        b_rd_en,
    output logic [HALF_WORD-1:0]        s_rd_addr,
    output logic [HALF_WORD-1:0]        w_rd_addr,
    output logic [HALF_WORD-1:0]        b_rd_addr,
    input  logic signed [DATA_W-1:0]    s_rd_data,
    input  logic signed [COEF_W-1:0]    w_rd_data,
    input  logic signed [BYTE-1:0]      b_rd_data,
    output logic                        out_we,
    output logic [HALF_WORD-1:0]        out_addr,
    output logic signed [BYTE-1:0]      out_data,
    output logic                        busy,
    output logic                        done,
    output logic [HALF_WORD-1:0]        sat_count
);

    assign s_rd_en   = en_sum;
    assign w_rd_en   = en_sum;
    assign b_rd_en   = save;
    assign s_rd_addr = s_addr;
    assign w_rd_addr = w_addr;
    assign b_rd_addr = b_addr;

    ctrl_t                              ctl_p0;
    ctrl_t                              ctl_p1;
    logic                               save_p2;
    logic                               fin_p2;
    logic [HALF_WORD-1:0]               addr_p0;
    logic [HALF_WORD-1:0]               addr_p1;
    logic [HALF_WORD-1:0]               addr_p2;
    logic signed [DATA_W+COEF_W-1:0]    prod_p1;
    logic signed [WORD-1:0]             bias_p1;
    logic signed [WORD-1:0]             acc;
    logic signed [SUM_W-1:0]            sum_p2;

    logic signed [WORD-1:0]             bias_ext;
    logic signed [SUM_W-1:0]            term_c;
    logic signed [SUM_W-1:0]            sum_c;
    logic signed [BYTE-1:0]             q;
    logic                               sat;

    assign bias_ext = WORD'(b_rd_data);

    always_comb begin
        term_c = '0;
        if (ctl_p1.vld) term_c = SUM_W'(prod_p1);
        sum_c = SUM_W'(acc) + term_c + SUM_W'(bias_p1);
    end

    conv_requant #(
        .OUT_SHIFT (OUT_SHIFT),
        .RELU      (RELU)
    ) u_requant (
        .sum (sum_p2),
        .q   (q),
        .sat (sat)
    );

    // Datapath registers: no reset, qualified downstream by the control bits.
    always_ff @(posedge clk) begin
        // S0
        addr_p0 <= save_addr;
        // S1: memories returned data for the S0 addresses
        prod_p1 <= s_rd_data * w_rd_data;
        bias_p1 <= bias_ext <<< BIAS_SHIFT;
        addr_p1 <= addr_p0;
        // S2
        sum_p2  <= sum_c;
        addr_p2 <= addr_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_p0    <= '0;
            ctl_p1    <= '0;
            save_p2   <= 1'b0;
            fin_p2    <= 1'b0;
            acc       <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            sat_count <= '0;
        end else begin
            // S0
            ctl_p0 <= '{vld: en_sum, save: save, fin: finish};
            // S1
            ctl_p1 <= ctl_p0;
            // S2
            save_p2 <= ctl_p1.save;
            fin_p2  <= ctl_p1.fin;
            if (ctl_p1.save)     acc <= '0;
            else if (ctl_p1.vld) acc <= acc + WORD'(prod_p1);
            // S3: output registers
            out_we <= save_p2;
            done   <= fin_p2;
            if (save_p2) begin
                out_data <= q;
                out_addr <= addr_p2;
                if (sat && sat_count != '1) sat_count <= sat_count + 1'b1;
            end
            // New activity keeps busy set even if an earlier finish completes on this edge.
            if (en_sum || save) busy <= 1'b1;
            else if (fin_p2)    busy <= 1'b0;
        end
    end

endmodule

// File: doc/conv_accum.md
# conv_accum

Datapath consumer for the convolution address/control sequence. Per active cycle it fetches an input pixel and a weight from the addresses supplied by the controller, accumulates their signed product, and on each `save` marker adds the bias, requantizes to 8 bits and writes one output pixel. It sits between the convolution controller and the input, weight, bias and output memories. It is the execute end of the `en_sum`/`save`/`finish` protocol the controller issues.

## Interface
Parameters:
- `OUT_SHIFT`, 9: arithmetic right shift applied to the final sum; 0–31.
- `BIAS_SHIFT`, 0: left shift applied to the bias before it is added; 0–15.
- `RELU`, 0: when 1, negative results are clamped to 0 after saturation.

Ports:
- `clk` input 1: clock. All logic is clocked on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en_sum` input 1: the current cycle contributes one product term.
- `save` input 1: the current cycle closes the output window.
- `finish` input 1: single-cycle pulse marking the last controller cycle.
- `s_addr`, `w_addr`, `b_addr`, `save_addr` input 16 each: addresses from the controller.
- `s_rd_en`, `w_rd_en`, `b_rd_en` output 1 each: memory read strobes.
- `s_rd_addr`, `w_rd_addr`, `b_rd_addr` output 16 each: memory read addresses.
- `s_rd_data`, `w_rd_data` input 8 each: signed read data, valid one cycle after the strobe.
- `b_rd_data` input 8: signed bias, valid one cycle after `b_rd_en`.
- `out_we` output 1: output write strobe.
- `out_addr` output 16: output write address.
- `out_data` output 8: signed output pixel.
- `busy` output 1: a window is open or the pipeline is occupied.
- `done` output 1: single-cycle completion pulse.
- `sat_count` output 16: number of saturated outputs since reset; holds at 0xFFFF.

## Operation
- Read issue is combinational pass-through:
  - `s_rd_en = w_rd_en = en_sum` and `b_rd_en = save`.
  - `*_rd_addr` equals the matching input address.
  - Memories sample on the same edge that registers S0.
- Pipeline stages:
  - S0: register `en_sum`, `save`, `finish`, `save_addr`.
  - S1: register the 16-bit signed product `s_rd_data*w_rd_data`, register the bias sign-extended to 32 bits and shifted left by `BIAS_SHIFT`, and carry the control bits.
  - S2: update the accumulator and the output registers.
- Accumulator is 32-bit signed and wraps on overflow in two's complement.
- S2 behaviour:
  - If valid and not save: `acc <= acc + prod`.
  - If save: compute `sum = acc + (valid ? prod : 0) + bias`, then `acc <= 0`.
  - The save path writes `out_data = requant(sum)`, `out_addr = saved addr`, and sets `out_we = 1`.
- `save` without `en_sum` is legal. It finalizes using the current accumulator and issues no `s`/`w` read.
- `requant(sum)` is computed in 33-bit arithmetic:
  - `r = (sum + (OUT_SHIFT ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT`.
  - Saturate `r` to [-128, 127].
  - If `RELU`, clamp negative values to 0.
  - `sat_count` increments when saturation clipped the value. A ReLU clamp does not count.
- `busy` sets on `en_sum` or `save` sampled in S0. It clears on the cycle `done` is asserted.
- `done` is the S0 `finish` bit delayed through S1 and S2, so it is coincident with the final `out_we` when `finish` arrives together with `save`.

## Timing
- Reset values: all outputs 0, `acc` 0, pipeline valid bits 0, `sat_count` 0.
- Latency: `save` sampled at edge E0 gives `out_we` high for exactly one cycle after edge E0+3. `done` has the same latency.
- Throughput: one term per cycle with no stalls.
- Back-to-back windows (`save` in consecutive cycles) are legal. Each produces one write, and no term leaks across windows.
- `en_sum` and `save` in the same cycle: the term belongs to the closing window.
- Reset mid-window or mid-pipeline:
  - In-flight terms and pending writes are dropped; no `out_we` follows reset.
  - The accumulator is cleared.
- `finish` without a preceding `save`: `done` still pulses and no write occurs.

## Structure
- Add `` `WORD`` (32) to `parameters.v` for the accumulator width. Use `` `BYTE`` for data and `` `HALF_WORD`` for addresses.
- `OUT_SHIFT` and `BIAS_SHIFT` defaults live in `parameters.v` next to the existing convolution constants.
- One combinational sub-module, `conv_requant`: 33-bit input plus shift, outputs int8 value and a saturation flag.
- `conv_accum` is instantiated beside the controller. Its `en_sum`, `save`, `finish` and address inputs connect directly to the controller outputs.

## Test plan
- Basic window: `OUT_SHIFT`=0, three terms (3,4), bias 5, `save_addr` 7. Expect `out_we` at E0+3 with `out_addr`=7 and `out_data`=41.
- Rounding: `OUT_SHIFT`=2.
  - Sum -6 gives -1.
  - Sum 6 gives 2.
  - Sum 5 gives 1.
- Saturation: 25 terms of 127×127 gives `out_data`=127 and `sat_count`=1. 25 terms of −128×127 gives −128 and `sat_count`=2.
- `RELU`=1: sum −20 gives `out_data`=0 with `sat_count` unchanged.
- Back-to-back: `save` on every cycle with terms 2×2 then 3×3, bias 0, `OUT_SHIFT`=0. Expect consecutive writes 4 then 9, `done` aligned with the last write, and `busy` low afterwards.
- Reset asserted one cycle after `save`: no `out_we` follows. A following window of 1×1 writes 1 (no residue).
